// File: rtl/k6502_io_pkg.sv
// Shared register offsets, CTRL bit positions and timer state type for the k6502 I/O responder.
package k6502_io_pkg;

  localparam logic [2:0] IO_LED       = 3'd0;
  localparam logic [2:0] IO_RELOAD_LO = 3'd1;
  localparam logic [2:0] IO_RELOAD_HI = 3'd2;
  localparam logic [2:0] IO_CTRL      = 3'd3;
  localparam logic [2:0] IO_COUNT_LO  = 3'd4;
  localparam logic [2:0] IO_COUNT_HI  = 3'd5;
  localparam logic [2:0] IO_PRESCALE  = 3'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_FLAG = 7;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

  function automatic logic [7:0] ctrl_byte(input logic en, input logic ie, input logic flag);
    logic [7:0] b;
    b            = 8'h00;
    b[CTRL_EN]   = en;
    b[CTRL_IE]   = ie;
    b[CTRL_FLAG] = flag;
    return b;
  endfunction

endpackage

// File: rtl/k6502_io_if.sv
// k6502 CPU-side bus bundle: address, write data, direction, read data and output enable.
interface k6502_io_if;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        rw;
  logic [7:0]  d_out;
  logic        oe_n;

  modport master (output a, d_in, rw, input d_out, oe_n);
  modport slave  (input a, d_in, rw, output d_out, oe_n);
endinterface

// File: rtl/k6502_io_timer.sv
// 16-bit interval timer: counter, reload register, FLAG, optional prescaler (K6502_IO_PRESCALE_EN).
//   state  | meaning
//   T_IDLE | EN=0, counter holds its value
//   T_RUN  | EN=1, counter decrements each tick, reloads and sets FLAG at 0
module k6502_io_timer
  import k6502_io_pkg::*;
#(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  d,
  input  logic        lo_wr,
  input  logic        hi_wr,
  input  logic        ctrl_wr,
`ifdef K6502_IO_PRESCALE_EN
  input  logic        psc_wr,
  output logic [7:0]  prescale,
`endif
  output logic [15:0] count,
  output logic [15:0] reload,
  output logic        en,
  output logic        flag
);

  timer_state_e state, state_nxt;
  logic run, en_rise, flag_clr, tick, expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= T_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ctrl_wr) state_nxt = d[CTRL_EN] ? T_RUN : T_IDLE;
  end

  always_comb begin
    run      = (state == T_RUN);
    en       = run;
    en_rise  = ctrl_wr & d[CTRL_EN] & ~run;
    flag_clr = ctrl_wr & d[CTRL_FLAG];
  end

`ifdef K6502_IO_PRESCALE_EN
  logic [7:0] psc;
  logic       psc_hit;
  assign psc_hit = (psc == prescale);
  assign tick    = run & psc_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc      <= 8'h00;
      prescale <= 8'h00;
    end else begin
      if (psc_wr) prescale <= d;
      if (hi_wr | en_rise | psc_hit) psc <= 8'h00;
      else                           psc <= psc + 8'd1;
    end
  end
`else
  assign tick = run;
`endif

  assign expire = tick & (count == 16'h0000);

  // A RELOAD_HI write overrides the counter, but an expiry on that edge still raises FLAG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= RELOAD_RST;
      reload <= RELOAD_RST;
      flag   <= 1'b0;
    end else begin
      if (lo_wr) reload[7:0]  <= d;
      if (hi_wr) reload[15:8] <= d;
      if (hi_wr)       count <= {d, reload[7:0]};
      else if (expire) count <= reload;
      else if (tick)   count <= count - 16'd1;
      if (expire)        flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;
    end
  end

endmodule

// File: rtl/k6502_io.sv
// k6502 memory-mapped I/O target: decode, read mux, LED register, IE and irq_n.
// Optional prescaler register at offset 6 when K6502_IO_PRESCALE_EN is defined.
module k6502_io
  import k6502_io_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'h4000,
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  k6502_io_if.slave   bus,
  output logic [3:0]  led,
  output logic        irq_n
);

  logic        cs, wr;
  logic [2:0]  off;
  logic        lo_wr, hi_wr, ctrl_wr;
  logic [15:0] count, reload;
  logic        en, flag, ie;
  logic [7:0]  rdata;

  assign cs       = (bus.a[15:3] == BASE[15:3]);
  assign off      = bus.a[2:0];
  assign wr       = cs & ~bus.rw;
  assign bus.oe_n = ~(cs & bus.rw);

  assign lo_wr   = wr & (off == IO_RELOAD_LO);
  assign hi_wr   = wr & (off == IO_RELOAD_HI);
  assign ctrl_wr = wr & (off == IO_CTRL);

`ifdef K6502_IO_PRESCALE_EN
  logic       psc_wr;
  logic [7:0] prescale;
  assign psc_wr = wr & (off == IO_PRESCALE);
`endif

  k6502_io_timer #(.RELOAD_RST(RELOAD_RST)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (bus.d_in),
    .lo_wr    (lo_wr),
    .hi_wr    (hi_wr),
    .ctrl_wr  (ctrl_wr),
`ifdef K6502_IO_PRESCALE_EN
    .psc_wr   (psc_wr),
    .prescale (prescale),
`endif
    .count    (count),
    .reload   (reload),
    .en       (en),
    .flag     (flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led   <= 4'h0;
      ie    <= 1'b0;
      irq_n <= 1'b1;
    end else begin
      if (wr && off == IO_LED) led <= bus.d_in[3:0];
      if (ctrl_wr)             ie  <= bus.d_in[CTRL_IE];
      irq_n <= ~(flag & ie);
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (cs) begin
      case (off)
        IO_LED:       rdata = {4'h0, led};
        IO_RELOAD_LO: rdata = reload[7:0];
        IO_RELOAD_HI: rdata = reload[15:8];
        IO_CTRL:      rdata = ctrl_byte(en, ie, flag);
        IO_COUNT_LO:  rdata = count[7:0];
        IO_COUNT_HI:  rdata = count[15:8];
`ifdef K6502_IO_PRESCALE_EN
        IO_PRESCALE:  rdata = prescale;
`endif
        default:      rdata = 8'h00;
      endcase
    end
  end

  assign bus.d_out = rdata;

endmodule

// File: tb/tb_k6502_io.sv
// Directed test of k6502_io: decode, LED register, timer expiry, FLAG priorities, async reset.
`timescale 1ns/100ps
module tb_k6502_io;

  localparam logic [15:0] BASE = 16'h4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] led;
  logic       irq_n;
  int         n_checks = 0;
  int         n_fail   = 0;

  k6502_io_if bus_if();

  k6502_io #(.BASE(BASE), .RELOAD_RST(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .led   (led),
    .irq_n (irq_n)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
    bus_if.a  = BASE + {13'd0, off};
    bus_if.rw = 1'b1;
    #1;
    check_eq(tag, {8'h00, bus_if.d_out}, {8'h00, exp});
  endtask

  // Called in the low clock phase; the write lands on the next posedge, returns at the following negedge.
  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    bus_if.a    = addr;
    bus_if.d_in = data;
    bus_if.rw   = 1'b0;
    @(negedge clk);
    bus_if.rw   = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_if.a    = 16'h0000;
    bus_if.d_in = 8'h00;
    bus_if.rw   = 1'b1;
    #25;
    check_eq("rst_led", {12'h0, led}, 16'h0);
    check_eq("rst_irq", {15'h0, irq_n}, 16'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode and reset values
    @(negedge clk);
    bus_if.a = BASE; bus_if.rw = 1'b0; #1;
    check_eq("oe_write", {15'h0, bus_if.oe_n}, 16'h1);
    bus_if.rw = 1'b1; #1;
    check_eq("oe_base", {15'h0, bus_if.oe_n}, 16'h0);
    bus_if.a = BASE + 16'd7; #1;
    check_eq("oe_base7", {15'h0, bus_if.oe_n}, 16'h0);
    bus_if.a = BASE + 16'd8; #1;
    check_eq("oe_base8", {15'h0, bus_if.oe_n}, 16'h1);
    check_eq("rd_unsel", {8'h0, bus_if.d_out}, 16'h0);
    bus_if.a = BASE - 16'd1; #1;
    check_eq("oe_below", {15'h0, bus_if.oe_n}, 16'h1);
    @(negedge clk);
    check_rd("rst_r0", 3'd0, 8'h00);
    check_rd("rst_r1", 3'd1, 8'hFF);
    check_rd("rst_r2", 3'd2, 8'hFF);
    check_rd("rst_r3", 3'd3, 8'h00);
    check_rd("rst_r4", 3'd4, 8'hFF);
    check_rd("rst_r5", 3'd5, 8'hFF);
    check_rd("rst_r7", 3'd7, 8'h00);

    // LED register
    @(negedge clk);
    wr_reg(BASE, 8'hA5);
    check_eq("led_a5", {12'h0, led}, 16'h5);
    check_rd("led_rd", 3'd0, 8'h05);
    bus_if.a = BASE + 16'd8; bus_if.d_in = 8'hFF; bus_if.rw = 1'b0; #1;
    check_eq("oe_wr8", {15'h0, bus_if.oe_n}, 16'h1);
    @(negedge clk);
    bus_if.rw = 1'b1;
    check_eq("led_keep", {12'h0, led}, 16'h5);

    // Timer, reload = 3
    wr_reg(BASE + 16'd1, 8'h03);
    wr_reg(BASE + 16'd2, 8'h00);
    wr_reg(BASE + 16'd3, 8'h03);
    check_rd("cnt_3", 3'd4, 8'h03);
    check_rd("cnt_hi", 3'd5, 8'h00);
    check_rd("ctrl_03", 3'd3, 8'h03);
    @(negedge clk); check_rd("cnt_2", 3'd4, 8'h02);
    @(negedge clk); check_rd("cnt_1", 3'd4, 8'h01);
    @(negedge clk); check_rd("cnt_0", 3'd4, 8'h00);
    check_rd("flag_pre", 3'd3, 8'h03);
    @(negedge clk); check_rd("cnt_rl", 3'd4, 8'h03);
    check_rd("flag_set", 3'd3, 8'h83);
    check_eq("irq_lag", {15'h0, irq_n}, 16'h1);
    @(negedge clk); check_rd("cnt_2b", 3'd4, 8'h02);
    check_eq("irq_low", {15'h0, irq_n}, 16'h0);
    @(negedge clk);
    @(negedge clk); check_rd("cnt_0b", 3'd4, 8'h00);

    // Clear on expiry edge: set wins
    wr_reg(BASE + 16'd3, 8'h83);
    check_rd("cnt_rl2", 3'd4, 8'h03);
    check_rd("clr_lose", 3'd3, 8'h83);
    // Clear on a non-expiry edge
    wr_reg(BASE + 16'd3, 8'h83);
    check_rd("clr_win", 3'd3, 8'h03);
    check_eq("irq_still", {15'h0, irq_n}, 16'h0);

    // Reload change mid-count
    wr_reg(BASE + 16'd1, 8'h10);
    check_rd("cnt_1c", 3'd4, 8'h01);
    check_eq("irq_rel", {15'h0, irq_n}, 16'h1);
    wr_reg(BASE + 16'd2, 8'h00);
    check_rd("hi_ld_lo", 3'd4, 8'h10);
    check_rd("hi_ld_hi", 3'd5, 8'h00);
    check_rd("no_exp", 3'd3, 8'h03);
    @(negedge clk); check_rd("cnt_0f", 3'd4, 8'h0F);

    // Stop and resume
    wr_reg(BASE + 16'd3, 8'h02);
    check_rd("stop_cnt", 3'd4, 8'h0E);
    check_rd("stop_ctl", 3'd3, 8'h02);
    @(negedge clk); check_rd("hold", 3'd4, 8'h0E);
    wr_reg(BASE + 16'd3, 8'h03);
    check_rd("resume0", 3'd4, 8'h0E);
    @(negedge clk); check_rd("resume1", 3'd4, 8'h0D);

    // RELOAD_HI write coinciding with expiry
    wr_reg(BASE + 16'd1, 8'h00);
    wr_reg(BASE + 16'd2, 8'h00);
    check_rd("z_lo", 3'd4, 8'h00);
    check_rd("z_hi", 3'd5, 8'h00);
    check_rd("z_ctl", 3'd3, 8'h03);
    wr_reg(BASE + 16'd2, 8'h01);
    check_rd("hx_lo", 3'd4, 8'h00);
    check_rd("hx_hi", 3'd5, 8'h01);
    check_rd("hx_flag", 3'd3, 8'h83);
    @(negedge clk);
    check_rd("hx_dec", 3'd4, 8'hFF);
    check_rd("hx_dech", 3'd5, 8'h00);
    check_eq("hx_irq", {15'h0, irq_n}, 16'h0);

    // Asynchronous reset mid-operation
    rst_n = 1'b0; #1;
    check_eq("ar_led", {12'h0, led}, 16'h0);
    check_eq("ar_irq", {15'h0, irq_n}, 16'h1);
    check_rd("ar_ctl", 3'd3, 8'h00);
    check_rd("ar_rlo", 3'd1, 8'hFF);
    check_rd("ar_cnt", 3'd4, 8'hFF);
    check_rd("ar_cnth", 3'd5, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef K6502_IO_PRESCALE_EN
    begin
      logic [7:0] exp_cnt [7];
      exp_cnt = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
      wr_reg(BASE + 16'd6, 8'h02);
      check_rd("psc_rd", 3'd6, 8'h02);
      wr_reg(BASE + 16'd1, 8'h01);
      wr_reg(BASE + 16'd2, 8'h00);
      wr_reg(BASE + 16'd3, 8'h01);
      for (int i = 0; i < 7; i++) begin
        if (i > 0) @(negedge clk);
        check_rd($sformatf("psc_cnt%0d", i), 3'd4, exp_cnt[i]);
        check_rd($sformatf("psc_flg%0d", i), 3'd3, (i == 6) ? 8'h81 : 8'h01);
      end
    end
`else
    wr_reg(BASE + 16'd6, 8'h55);
    check_rd("r6_zero", 3'd6, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
